// File: rtl/spi_resp_pkg.sv
// rtl/spi_resp_pkg.sv - shared constants and types for the SPI slave responder
//
// Purpose: command byte values, FSM state encoding and the status-byte layout
// used by spi_resp_model.
// Ports: none (package).

package spi_resp_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } state_t;

  // Status byte returned by CMD_STATUS, MSB first on the wire.
  typedef struct packed {
    logic       sticky_err;
    logic       rsvd;
    logic [5:0] wr_cnt_lo;
  } status_t;

  function automatic status_t pack_status(input logic err, input logic [5:0] cnt);
    status_t s;
    s.sticky_err = err;
    s.rsvd       = 1'b0;
    s.wr_cnt_lo  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// rtl/spi_resp_sync.sv - two-flop synchronizer with registered edge detect
//
// Purpose: brings one asynchronous SPI pin into the s_clk domain and flags
// its rising and falling edges.
// Ports:
//   s_clk, rst_n : system clock, asynchronous active-low reset
//   din          : asynchronous pin
//   level        : synchronized level, aligned with rise/fall
//   rise, fall   : one-cycle edge pulses, 3 s_clk cycles after the pin edge

module spi_resp_sync (
  input  logic s_clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       last_q;

  // Everything resets to 0 so a csn that is already low when reset releases
  // is not mistaken for a new chip-select fall.
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      last_q <= sync_q[1];
      rise   <= sync_q[1] & ~last_q;
      fall   <= ~sync_q[1] & last_q;
    end
  end

  assign level = last_q;

endmodule

// File: rtl/spi_resp_model.sv
// rtl/spi_resp_model.sv - SPI slave responder for PULPino SPI-slave memory commands
//
// Purpose: answers write (0x02), read (0x0B) and optionally status (0x05)
// commands from an SPI master against an internal word memory, with a
// registered debug read port and a saturating write counter.
// Optional feature macro: SPI_RESP_STATUS_EN enables the 0x05 status command.
// Ports:
//   s_clk, rst_n          : system clock, asynchronous active-low reset
//   spi_sck_i, spi_csn_i  : SPI clock (mode 0) and chip select, asynchronous
//   spi_sdi0_i/spi_sdo0_o : serial data in / out, MSB first
//   dbg_addr_i/dbg_rdata_o: debug word index and registered memory word
//   wr_cnt_o              : words written since reset, saturating
//   busy_o                : transaction in progress
//   cmd_err_o             : one-cycle pulse on an unknown command byte

module spi_resp_model
  import spi_resp_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int DUMMY_CYCLES = 32
) (
  input  logic                     s_clk,
  input  logic                     rst_n,
  input  logic                     spi_sck_i,
  input  logic                     spi_csn_i,
  input  logic                     spi_sdi0_i,
  output logic                     spi_sdo0_o,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  output logic [31:0]              dbg_rdata_o,
  output logic [15:0]              wr_cnt_o,
  output logic                     busy_o,
  output logic                     cmd_err_o
);

  localparam int AW = $clog2(DEPTH);

  logic sck_lvl, sck_rise, sck_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  spi_resp_sync u_sync_sck (.s_clk(s_clk), .rst_n(rst_n), .din(spi_sck_i),
                            .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_resp_sync u_sync_csn (.s_clk(s_clk), .rst_n(rst_n), .din(spi_csn_i),
                            .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
  spi_resp_sync u_sync_sdi (.s_clk(s_clk), .rst_n(rst_n), .din(spi_sdi0_i),
                            .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, csn_lvl, sdi_rise, sdi_fall};

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [30:0]   shift_q, shift_d;
  logic [31:0]   shift_in;
  logic [AW-1:0] idx_q, idx_d, idx_nx;
  logic          is_rd_q, is_rd_d;
  logic [31:0]   tx_q, tx_d;
  logic          sdo_q, sdo_d;
  logic          cmd_err_q, cmd_err_d;
  logic [15:0]   wr_cnt_q;
  logic [31:0]   dbg_q;
  logic          mem_we;
`ifdef SPI_RESP_STATUS_EN
  logic          stat_q, stat_d;
  logic          sticky_q, sticky_d;
`endif

  assign shift_in = {shift_q, sdi_lvl};
  assign idx_nx   = idx_q + AW'(1);

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    is_rd_d   = is_rd_q;
    tx_d      = tx_q;
    sdo_d     = (state_q == ST_RDATA) ? sdo_q : 1'b0;
    mem_we    = 1'b0;
    cmd_err_d = 1'b0;
`ifdef SPI_RESP_STATUS_EN
    stat_d    = stat_q;
    sticky_d  = sticky_q;
`endif
    // csn rise wins over any same-cycle sck edge, dropping that bit.
    if (csn_rise) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b0;
`ifdef SPI_RESP_STATUS_EN
      stat_d  = 1'b0;
      if (stat_q) sticky_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csn_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            shift_d = shift_in[30:0];
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d = '0;
              if (shift_in[7:0] == CMD_WRITE || shift_in[7:0] == CMD_READ) begin
                state_d = ST_ADDR;
                is_rd_d = (shift_in[7:0] == CMD_READ);
              end
`ifdef SPI_RESP_STATUS_EN
              else if (shift_in[7:0] == CMD_STATUS) begin
                state_d = ST_RDATA;
                stat_d  = 1'b1;
                tx_d    = {pack_status(sticky_q, wr_cnt_q[5:0]), 24'h0};
              end
`endif
              else begin
                cmd_err_d = 1'b1;
                state_d   = ST_SKIP;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            shift_d = shift_in[30:0];
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'd31) begin
              cnt_d   = '0;
              idx_d   = shift_in[AW+1:2];
              state_d = is_rd_q ? ST_DUMMY : ST_WDATA;
            end
          end
        end
        ST_DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = ST_RDATA;
              tx_d    = mem[idx_q];
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise) begin
            shift_d = shift_in[30:0];
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'd31) begin
              cnt_d  = '0;
              mem_we = 1'b1;
              idx_d  = idx_nx;
            end
          end
        end
        ST_RDATA: begin
          if (sck_fall) begin
            sdo_d = tx_q[31];
            tx_d  = {tx_q[30:0], 1'b0};
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd31) begin
              cnt_d = '0;
              idx_d = idx_nx;
`ifdef SPI_RESP_STATUS_EN
              // Status streams zeros after its byte instead of memory words.
              if (!stat_q) tx_d = mem[idx_nx];
`else
              tx_d = mem[idx_nx];
`endif
            end
          end
        end
        ST_SKIP: ;
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef SPI_RESP_STATUS_EN
    if (cmd_err_d) sticky_d = 1'b1;
`endif
  end

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      is_rd_q   <= 1'b0;
      tx_q      <= '0;
      sdo_q     <= 1'b0;
      cmd_err_q <= 1'b0;
      wr_cnt_q  <= '0;
      dbg_q     <= '0;
`ifdef SPI_RESP_STATUS_EN
      stat_q    <= 1'b0;
      sticky_q  <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      is_rd_q   <= is_rd_d;
      tx_q      <= tx_d;
      sdo_q     <= sdo_d;
      cmd_err_q <= cmd_err_d;
      if (mem_we && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      // Reads the pre-write contents on a same-cycle collision.
      dbg_q     <= mem[dbg_addr_i];
`ifdef SPI_RESP_STATUS_EN
      stat_q    <= stat_d;
      sticky_q  <= sticky_d;
`endif
    end
  end

  always_ff @(posedge s_clk) begin
    if (mem_we) mem[idx_q] <= shift_in;
  end

  assign spi_sdo0_o  = sdo_q;
  assign dbg_rdata_o = dbg_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign cmd_err_o   = cmd_err_q;

endmodule
